dma_priority_arbiter: RTL and testbench
=======================================

Name: dma_priority_arbiter

Overview:
- Channel request arbiter and bus-handshake sequencer for the 8237A-5 DMA controller model.
- Combines hardware DREQ inputs, mask bits and software requests; raises HRQ to the CPU and waits for HLDA.
- Resolves fixed or rotating priority, then asserts DACK for the winning channel.
- Hands the grant to the transfer timing FSM via START and releases the bus on SVC_DONE.

Parameters:
- NUM_CH, 4: number of DMA channels; the RTL and the bench are checked at 4 only.

Ports:
- CLOCK  in  1  system clock; all state updates on posedge.
- RESET_N  in  1  asynchronous active-low reset.
- DREQ  in  NUM_CH  channel DMA requests; polarity set by CMD_DREQ_SENSE.
- MASK  in  NUM_CH  per-channel mask bit; 1 blocks DREQ for that channel.
- SW_REQ  in  NUM_CH  software request bits; not affected by MASK or DREQ sense.
- CMD_DISABLE  in  1  controller disable; 1 blocks all new arbitration.
- CMD_ROT  in  1  1 = rotating priority, 0 = fixed priority.
- CMD_DREQ_SENSE  in  1  1 = DREQ active low, 0 = DREQ active high.
- CMD_DACK_SENSE  in  1  1 = DACK active high, 0 = DACK active low.
- HLDA  in  1  hold acknowledge from the CPU.
- SVC_DONE  in  1  one-cycle pulse from the timing FSM when the granted service ends (TC, EOP or single transfer).
- HRQ  out  1  hold request to the CPU.
- DACK  out  NUM_CH  channel acknowledges, one-hot when active; polarity per CMD_DACK_SENSE.
- START  out  1  one-cycle pulse telling the timing FSM to begin service.
- GNT_CH  out  2  index of the granted channel; valid while GNT_VALID=1.
- GNT_VALID  out  1  high from the START cycle until the cycle after SVC_DONE.

Behaviour:
- Effective request: EREQ = CMD_DISABLE ? 0 : (((DREQ ^ {NUM_CH{CMD_DREQ_SENSE}}) & ~MASK) | SW_REQ).
- FSM states: IDLE, REQ, GRANT, SERVICE, RELEASE. Reset state is IDLE.
- Reset values: HRQ=0, START=0, GNT_VALID=0, GNT_CH=0, priority pointer PTR=0, internal one-hot grant=0.
- DACK = grant ^ {NUM_CH{~CMD_DACK_SENSE}}. At reset DACK is all inactive for the current sense.
- IDLE: if any EREQ bit is set, go to REQ next cycle; HRQ is registered high one cycle after the request appears.
- REQ: HRQ=1.
  - If HLDA=1 and EREQ≠0: latch the winner and go to GRANT.
  - If HLDA=1 and EREQ=0: go to RELEASE.
  - If HLDA=0 and EREQ=0: HRQ=0 and return to IDLE.
- Winner selection in fixed mode: lowest index wins (ch0 highest).
- Winner selection in rotating mode: search starts at PTR and wraps modulo NUM_CH.
- GRANT (one cycle): START=1, GNT_VALID=1, GNT_CH=winner, DACK active for the winner; then go to SERVICE.
- SERVICE: hold HRQ, DACK and GNT_CH.
  - MASK, DREQ and CMD_* changes have no effect on the active grant. Exception: CMD_DACK_SENSE changes DACK polarity immediately, because polarity is applied combinationally.
  - On SVC_DONE: in rotating mode set PTR=(GNT_CH+1) mod NUM_CH, so the served channel becomes lowest priority. Then go to RELEASE.
  - HLDA falling while in SERVICE is an abort: clear the grant, leave PTR unchanged, go to IDLE with HRQ=0. The timing FSM is responsible for its own abort.
- RELEASE: HRQ=0, GNT_VALID=0, DACK inactive; wait for HLDA=0, then go to IDLE.
  - No new HRQ is raised until HLDA is low, even if requests are pending.
- SVC_DONE outside SERVICE is ignored.
- START never pulses twice for one grant.
- Async reset mid-service: all outputs take reset values immediately; no START is generated.
- Latency: EREQ to HRQ is 1 cycle. HLDA sampled high to START is 1 cycle.

Optional Feature:
- Macro: DMA_ROTATE_PRIORITY_EN.
- Defined: rotating priority as above, selected by CMD_ROT.
- Undefined: CMD_ROT is ignored, PTR is removed, priority is fixed (ch0 highest), and the rotation update on SVC_DONE is not compiled.

Decomposition:
- Shared package dma_pkg:
  - arb_state_t enum (IDLE, REQ, GRANT, SERVICE, RELEASE).
  - NUM_CH constant.
  - ch_idx_t typedef (logic [1:0]).
  - DACK/DREQ sense constants.
- Sub-module dma_priority_encoder: combinational; inputs req[NUM_CH] and ptr; outputs one-hot gnt, index and any. Reused for fixed mode with ptr=0.

Test Plan:
- Fixed priority, active-high DREQ: DREQ=4'b1010 with MASK=0. Expect HRQ 1 cycle later. After HLDA=1, expect START with GNT_CH=1 and DACK=4'b1101 (active-low sense).
- Rotating priority: DREQ=4'b1111 held, CMD_ROT=1, SVC_DONE after each grant. Expect grant order 0,1,2,3,0 and HRQ low between grants until HLDA falls.
- Mask and software request: MASK=4'b1111, DREQ=4'b1111 gives no HRQ. Then SW_REQ=4'b0100 gives GNT_CH=2. With CMD_DISABLE=1, DREQ=4'b0001 gives no HRQ.
- Request withdrawn: DREQ ch3 pulses 1 cycle with HLDA held low. Expect HRQ up 1 cycle, then drop and IDLE. If HLDA rises with EREQ=0, expect RELEASE with no START.
- HLDA abort: HLDA drops during SERVICE of ch2. Expect DACK inactive and HRQ=0 next cycle. PTR is unchanged, so the next DREQ=4'b1111 in rotating mode still grants the same channel as before.
- Async reset: assert RESET_N=0 mid-SERVICE between clock edges. Expect HRQ=0, GNT_VALID=0 and DACK inactive immediately. After release, DREQ=4'b0001 arbitrates normally with ch0.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared types and constants for the 8237A-5 DMA priority arbiter.
// Optional feature macro: DMA_ROTATE_PRIORITY_EN (rotating priority support).
package dma_pkg;

  localparam int NUM_CH = 4;

  typedef logic [1:0]        ch_idx_t;
  typedef logic [NUM_CH-1:0] ch_vec_t;

  // Arbiter/handshake sequencer states
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    GRANT   = 3'd2,
    SERVICE = 3'd3,
    RELEASE = 3'd4
  } arb_state_t;

  // CMD_DREQ_SENSE encodings
  localparam logic DREQ_SENSE_ACT_HIGH = 1'b0;
  localparam logic DREQ_SENSE_ACT_LOW  = 1'b1;

  // CMD_DACK_SENSE encodings
  localparam logic DACK_SENSE_ACT_LOW  = 1'b0;
  localparam logic DACK_SENSE_ACT_HIGH = 1'b1;

  // Effective request: hardware DREQ normalised to active-high and masked,
  // merged with software requests; a disabled controller sees nothing.
  function automatic ch_vec_t eff_req(input ch_vec_t dreq,
                                      input ch_vec_t mask,
                                      input ch_vec_t sw_req,
                                      input logic    dreq_sense,
                                      input logic    disable_ctl);
    ch_vec_t hw;
    hw = (dreq ^ {NUM_CH{dreq_sense}}) & ~mask;
    return disable_ctl ? '0 : (hw | sw_req);
  endfunction

endpackage

// File: rtl/dma_priority_encoder.sv
// Rotating-start priority encoder: the search begins at i_ptr and wraps,
// the first set request wins. With i_ptr = 0 it is a fixed ch0-highest encoder.
module dma_priority_encoder
  import dma_pkg::*;
(
  input  ch_vec_t i_req,
  input  ch_idx_t i_ptr,
  output ch_vec_t o_gnt,
  output ch_idx_t o_idx,
  output logic    o_any
);

  // Scan from lowest to highest priority so the highest-priority hit is written last
  always_comb begin
    ch_idx_t cand;
    // NOTE: every output gets a default before the loop; otherwise paths with no hit would infer latches.
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    cand  = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      cand = i_ptr + ch_idx_t'(i);
      if (i_req[cand]) begin
        o_gnt       = '0;
        o_gnt[cand] = 1'b1;
        o_idx       = cand;
        o_any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dma_priority_arbiter.sv
// DMA channel request arbiter and HRQ/HLDA bus-handshake sequencer.
// Optional feature macro: DMA_ROTATE_PRIORITY_EN. When undefined, CMD_ROT is
// ignored, no priority pointer exists and priority is fixed (ch0 highest).
module dma_priority_arbiter
  import dma_pkg::*;
(
  input  logic    CLOCK,
  input  logic    RESET_N,
  input  ch_vec_t DREQ,
  input  ch_vec_t MASK,
  input  ch_vec_t SW_REQ,
  input  logic    CMD_DISABLE,
  input  logic    CMD_ROT,
  input  logic    CMD_DREQ_SENSE,
  input  logic    CMD_DACK_SENSE,
  input  logic    HLDA,
  input  logic    SVC_DONE,
  output logic    HRQ,
  output ch_vec_t DACK,
  output logic    START,
  output ch_idx_t GNT_CH,
  output logic    GNT_VALID
);

  arb_state_t r_state, w_state_nxt;
  logic       r_hrq, w_hrq_nxt;
  logic       r_start, w_start_nxt;
  logic       r_gnt_valid, w_gnt_valid_nxt;
  ch_idx_t    r_gnt_ch, w_gnt_ch_nxt;
  ch_vec_t    r_grant, w_grant_nxt;

  ch_vec_t    w_ereq;
  ch_idx_t    w_ptr;
  ch_vec_t    w_enc_gnt;
  ch_idx_t    w_enc_idx;
  logic       w_enc_any;

  assign w_ereq = eff_req(DREQ, MASK, SW_REQ, CMD_DREQ_SENSE, CMD_DISABLE);

`ifdef DMA_ROTATE_PRIORITY_EN
  ch_idx_t r_ptr, w_ptr_nxt;
  assign w_ptr = CMD_ROT ? r_ptr : '0;
`else
  logic w_unused_rot;
  assign w_unused_rot = CMD_ROT;
  assign w_ptr        = '0;
`endif

  dma_priority_encoder u_enc (
    .i_req (w_ereq),
    .i_ptr (w_ptr),
    .o_gnt (w_enc_gnt),
    .o_idx (w_enc_idx),
    .o_any (w_enc_any)
  );

  // Next-state and next-output decode for the handshake sequencer
  always_comb begin
    w_state_nxt     = r_state;
    w_hrq_nxt       = r_hrq;
    w_start_nxt     = 1'b0;
    w_gnt_valid_nxt = r_gnt_valid;
    w_gnt_ch_nxt    = r_gnt_ch;
    w_grant_nxt     = r_grant;
`ifdef DMA_ROTATE_PRIORITY_EN
    w_ptr_nxt       = r_ptr;
`endif
    unique case (r_state)
      IDLE: begin
        if (w_enc_any) begin
          w_state_nxt = REQ;
          w_hrq_nxt   = 1'b1;
        end
      end
      REQ: begin
        if (HLDA && w_enc_any) begin
          w_state_nxt     = GRANT;
          w_start_nxt     = 1'b1;
          w_gnt_valid_nxt = 1'b1;
          w_gnt_ch_nxt    = w_enc_idx;
          w_grant_nxt     = w_enc_gnt;
        end else if (HLDA) begin
          w_state_nxt = RELEASE;
          w_hrq_nxt   = 1'b0;
        end else if (!w_enc_any) begin
          w_state_nxt = IDLE;
          w_hrq_nxt   = 1'b0;
        end
      end
      GRANT: begin
        // START is a single pulse; the grant is now frozen until service ends
        w_state_nxt = SERVICE;
      end
      SERVICE: begin
        if (!HLDA) begin
          // CPU took the bus back: abort without touching the priority pointer
          w_state_nxt     = IDLE;
          w_hrq_nxt       = 1'b0;
          w_gnt_valid_nxt = 1'b0;
          w_grant_nxt     = '0;
        end else if (SVC_DONE) begin
`ifdef DMA_ROTATE_PRIORITY_EN
          if (CMD_ROT) begin
            w_ptr_nxt = r_gnt_ch + ch_idx_t'(1);
          end
`endif
          w_state_nxt     = RELEASE;
          w_hrq_nxt       = 1'b0;
          w_gnt_valid_nxt = 1'b0;
          w_grant_nxt     = '0;
        end
      end
      RELEASE: begin
        // Hold off new requests until the CPU has dropped HLDA
        if (!HLDA) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt     = IDLE;
        w_hrq_nxt       = 1'b0;
        w_gnt_valid_nxt = 1'b0;
        w_grant_nxt     = '0;
      end
    endcase
  end

  // State and registered-output update
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state     <= IDLE;
      r_hrq       <= 1'b0;
      r_start     <= 1'b0;
      r_gnt_valid <= 1'b0;
      r_gnt_ch    <= '0;
      r_grant     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_state     <= w_state_nxt;
      r_hrq       <= w_hrq_nxt;
      r_start     <= w_start_nxt;
      r_gnt_valid <= w_gnt_valid_nxt;
      r_gnt_ch    <= w_gnt_ch_nxt;
      r_grant     <= w_grant_nxt;
    end
  end

`ifdef DMA_ROTATE_PRIORITY_EN
  // Rotating-priority pointer: channel that gets first look next arbitration
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_ptr <= '0;
    end else begin
      r_ptr <= w_ptr_nxt;
    end
  end
`endif

  assign HRQ       = r_hrq;
  assign START     = r_start;
  assign GNT_VALID = r_gnt_valid;
  assign GNT_CH    = r_gnt_ch;
  // Polarity applied combinationally so a sense change takes effect at once
  assign DACK      = r_grant ^ {NUM_CH{~CMD_DACK_SENSE}};

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Self-checking bench for dma_priority_arbiter: cycle vector table plus
// hand-written multi-cycle sequences (rotation, abort, async reset).
module tb_dma_priority_arbiter;
  import dma_pkg::*;

  logic    CLOCK = 1'b0;
  logic    RESET_N;
  ch_vec_t DREQ, MASK, SW_REQ;
  logic    CMD_DISABLE, CMD_ROT, CMD_DREQ_SENSE, CMD_DACK_SENSE;
  logic    HLDA, SVC_DONE;
  logic    HRQ, START, GNT_VALID;
  ch_vec_t DACK;
  ch_idx_t GNT_CH;

  int n_checks = 0;
  int n_fail   = 0;

  dma_priority_arbiter dut (
    .CLOCK          (CLOCK),
    .RESET_N        (RESET_N),
    .DREQ           (DREQ),
    .MASK           (MASK),
    .SW_REQ         (SW_REQ),
    .CMD_DISABLE    (CMD_DISABLE),
    .CMD_ROT        (CMD_ROT),
    .CMD_DREQ_SENSE (CMD_DREQ_SENSE),
    .CMD_DACK_SENSE (CMD_DACK_SENSE),
    .HLDA           (HLDA),
    .SVC_DONE       (SVC_DONE),
    .HRQ            (HRQ),
    .DACK           (DACK),
    .START          (START),
    .GNT_CH         (GNT_CH),
    .GNT_VALID      (GNT_VALID)
  );

  always #5 CLOCK = ~CLOCK;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  typedef struct {
    string      nm;
    logic [3:0] dreq, mask, sw;
    logic       dis, dsense, hlda, svc;
    logic       hrq, start, gv;
    logic [1:0] ch;
    logic [3:0] dack;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string nm,
                              input logic [3:0] dreq, input logic [3:0] mask,
                              input logic [3:0] sw, input logic dis,
                              input logic dsense, input logic hlda, input logic svc,
                              input logic hrq, input logic start, input logic gv,
                              input logic [1:0] ch, input logic [3:0] dack);
    vec_t v;
    v.nm = nm; v.dreq = dreq; v.mask = mask; v.sw = sw; v.dis = dis;
    v.dsense = dsense; v.hlda = hlda; v.svc = svc; v.hrq = hrq;
    v.start = start; v.gv = gv; v.ch = ch; v.dack = dack;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  // Active-low DACK pattern for one granted channel
  function automatic logic [3:0] dack_lo(input logic [1:0] ch);
    logic [3:0] d;
    d     = 4'b1111;
    d[ch] = 1'b0;
    return d;
  endfunction

  // Wait (bounded) for HRQ, answer with HLDA and check the grant; returns in SERVICE
  task automatic do_grant(input logic [1:0] exp_ch, input string nm);
    int n;
    n = 0;
    while (HRQ !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check({nm, ".hrq"}, HRQ, 1);
    HLDA = 1'b1;
    tick();
    check({nm, ".start"}, START, 1);
    check({nm, ".gv"}, GNT_VALID, 1);
    check({nm, ".ch"}, GNT_CH, exp_ch);
    check({nm, ".dack"}, DACK, dack_lo(exp_ch));
    tick();
    check({nm, ".start_once"}, START, 0);
  endtask

  // End the service, verify RELEASE holds HRQ low until HLDA falls
  task automatic finish_service(input string nm);
    SVC_DONE = 1'b1;
    tick();
    SVC_DONE = 1'b0;
    check({nm, ".rel_hrq"}, HRQ, 0);
    check({nm, ".rel_gv"}, GNT_VALID, 0);
    check({nm, ".rel_dack"}, DACK, 4'b1111);
    tick();
    check({nm, ".rel_hold"}, HRQ, 0);
    HLDA = 1'b0;
    tick();
    check({nm, ".idle_hrq"}, HRQ, 0);
  endtask

  logic [1:0] exp_ch;

  initial begin
    RESET_N = 1'b0;
    DREQ = '0; MASK = '0; SW_REQ = '0;
    CMD_DISABLE = 1'b0; CMD_ROT = 1'b0;
    CMD_DREQ_SENSE = DREQ_SENSE_ACT_HIGH; CMD_DACK_SENSE = DACK_SENSE_ACT_LOW;
    HLDA = 1'b0; SVC_DONE = 1'b0;

    //                name             dreq     mask     sw       dis   ds    hlda  svc   hrq   st    gv    ch     dack
    vecs.push_back(mk("fx_req",        4'b1010, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 4'b1111));
    vecs.push_back(mk("fx_grant",      4'b1010, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2'd1, 4'b1101));
    vecs.push_back(mk("fx_svc",        4'b1010, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 4'b1101));
    vecs.push_back(mk("fx_hold",       4'b0000, 4'b1111, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 4'b1101));
    vecs.push_back(mk("fx_done",       4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 4'b1111));
    vecs.push_back(mk("fx_rel_pend",   4'b1010, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 4'b1111));
    vecs.push_back(mk("fx_idle",       4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 4'b1111));
    vecs.push_back(mk("mk_block1",     4'b1111, 4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 4'b1111));
    vecs.push_back(mk("mk_block2",     4'b1111, 4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 4'b1111));
    vecs.push_back(mk("sw_req",        4'b1111, 4'b1111, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 4'b1111));
    vecs.push_back(mk("sw_grant",      4'b1111, 4'b1111, 4'b0100, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2'd2, 4'b1011));
    vecs.push_back(mk("sw_svc",        4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 4'b1011));
    vecs.push_back(mk("sw_done",       4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 4'b1111));
    vecs.push_back(mk("sw_idle",       4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 4'b1111));
    vecs.push_back(mk("dis1",          4'b0001, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 4'b1111));
    vecs.push_back(mk("dis2",          4'b0001, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 4'b1111));
    vecs.push_back(mk("wd_req",        4'b1000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 4'b1111));
    vecs.push_back(mk("wd_drop",       4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 4'b1111));
    vecs.push_back(mk("wd_idle",       4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 4'b1111));
    vecs.push_back(mk("rl_req",        4'b1000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 4'b1111));
    vecs.push_back(mk("rl_hlda",       4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 4'b1111));
    vecs.push_back(mk("rl_wait",       4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 4'b1111));
    vecs.push_back(mk("rl_idle",       4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 4'b1111));
    vecs.push_back(mk("sd_ignored",    4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 4'b1111));
    vecs.push_back(mk("ds_block",      4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 4'b1111));
    vecs.push_back(mk("ds_req",        4'b1011, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 4'b1111));
    vecs.push_back(mk("ds_grant",      4'b1011, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2'd2, 4'b1011));
    vecs.push_back(mk("ds_early_done", 4'b1011, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd2, 4'b1011));
    vecs.push_back(mk("ds_done",       4'b1011, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 4'b1111));
    vecs.push_back(mk("ds_idle",       4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 4'b1111));

    // Reset values, including DACK following the sense while in reset
    #1;
    check("rst.hrq", HRQ, 0);
    check("rst.start", START, 0);
    check("rst.gv", GNT_VALID, 0);
    check("rst.ch", GNT_CH, 0);
    check("rst.dack_lo", DACK, 4'b1111);
    CMD_DACK_SENSE = DACK_SENSE_ACT_HIGH;
    #1;
    check("rst.dack_hi", DACK, 4'b0000);
    CMD_DACK_SENSE = DACK_SENSE_ACT_LOW;
    @(negedge CLOCK);
    @(negedge CLOCK);
    RESET_N = 1'b1;

    // Cycle vector table
    for (int i = 0; i < vecs.size(); i++) begin
      DREQ = vecs[i].dreq; MASK = vecs[i].mask; SW_REQ = vecs[i].sw;
      CMD_DISABLE = vecs[i].dis; CMD_DREQ_SENSE = vecs[i].dsense;
      HLDA = vecs[i].hlda; SVC_DONE = vecs[i].svc;
      tick();
      check({vecs[i].nm, ".hrq"}, HRQ, vecs[i].hrq);
      check({vecs[i].nm, ".start"}, START, vecs[i].start);
      check({vecs[i].nm, ".gv"}, GNT_VALID, vecs[i].gv);
      check({vecs[i].nm, ".ch"}, GNT_CH, vecs[i].ch);
      check({vecs[i].nm, ".dack"}, DACK, vecs[i].dack);
    end
    DREQ = '0; MASK = '0; SW_REQ = '0; CMD_DISABLE = 1'b0;
    CMD_DREQ_SENSE = DREQ_SENSE_ACT_HIGH; HLDA = 1'b0; SVC_DONE = 1'b0;
    tick();

    // DACK polarity flips immediately during service; the grant itself holds
    DREQ = 4'b0010;
    do_grant(2'd1, "sense");
    CMD_DACK_SENSE = DACK_SENSE_ACT_HIGH;
    #1;
    check("sense.dack_hi", DACK, 4'b0010);
    CMD_DACK_SENSE = DACK_SENSE_ACT_LOW;
    #1;
    check("sense.dack_lo", DACK, 4'b1101);
    DREQ = '0;
    finish_service("sense");

    // Rotating priority with all channels requesting
    CMD_ROT = 1'b1;
    DREQ    = 4'b1111;
    for (int k = 0; k < 5; k++) begin
`ifdef DMA_ROTATE_PRIORITY_EN
      exp_ch = 2'(k % 4);
`else
      exp_ch = 2'd0;
`endif
      do_grant(exp_ch, $sformatf("rot%0d", k));
      finish_service($sformatf("rot%0d", k));
    end

    // Advance pointer once more, then abort a service with HLDA falling
`ifdef DMA_ROTATE_PRIORITY_EN
    exp_ch = 2'd1;
`else
    exp_ch = 2'd0;
`endif
    do_grant(exp_ch, "pre_abort");
    finish_service("pre_abort");
`ifdef DMA_ROTATE_PRIORITY_EN
    exp_ch = 2'd2;
`else
    exp_ch = 2'd0;
`endif
    do_grant(exp_ch, "abort");
    HLDA = 1'b0;
    tick();
    check("abort.hrq", HRQ, 0);
    check("abort.gv", GNT_VALID, 0);
    check("abort.dack", DACK, 4'b1111);
    check("abort.start", START, 0);
    do_grant(exp_ch, "post_abort");
    finish_service("post_abort");

    // Asynchronous reset in the middle of a service
    CMD_ROT = 1'b0;
    DREQ    = 4'b0010;
    do_grant(2'd1, "arst");
    #3;
    RESET_N = 1'b0;
    #1;
    check("arst.hrq", HRQ, 0);
    check("arst.gv", GNT_VALID, 0);
    check("arst.dack", DACK, 4'b1111);
    check("arst.ch", GNT_CH, 0);
    check("arst.start", START, 0);
    HLDA = 1'b0;
    DREQ = 4'b0001;
    tick();
    check("arst.hold_start", START, 0);
    check("arst.hold_hrq", HRQ, 0);
    @(negedge CLOCK);
    RESET_N = 1'b1;
    do_grant(2'd0, "after_rst");
    DREQ = '0;
    finish_service("after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
